sim_sw_status_mon: RTL and testbench

- Parametrised simulation-only monitor for SW test status and console traffic.
- Snoops write transactions into the sim SRAM window and decodes three fixed word offsets: status, console character and heartbeat.
- Buffers console characters in a FIFO with a valid/ready drain port.
- Tracks test phase in a state machine, enforces a heartbeat watchdog, and raises sticky done/pass/timeout flags for bench termination.
- Sits beside sim_sram in the top-level sim bench, fed by the sim SRAM interface write strobe, address and data.

---
 rtl/sim_sw_status_mon.sv | 203 ++++++++++++++++++++
 tb/tb_sim_sw_status_mon.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sim_sw_status_mon.sv
// Simulation-only monitor: snoops sim SRAM writes for SW status, console characters and heartbeats.
// Build option SIM_STATUS_MON_DRAIN_EN holds test_done_o until the console FIFO has drained.
module sim_sw_status_mon #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned FifoDepth     = 16,
    parameter int unsigned TimeoutCycles = 0,
    parameter int unsigned TimeoutWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] start_addr_i,
    input  logic                 wr_valid_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 char_valid_o,
    input  logic                 char_ready_i,
    output logic [7:0]           char_data_o,
    output logic [15:0]          status_o,
    output logic                 running_o,
    output logic                 test_done_o,
    output logic                 test_passed_o,
    output logic                 timeout_o,
    output logic                 overflow_o
);
    localparam int unsigned PtrWidth = $clog2(FifoDepth);
    localparam logic [PtrWidth:0] FifoFull = (PtrWidth+1)'(FifoDepth);
    localparam bit WdEnable = (TimeoutCycles != 32'd0);
    localparam logic [TimeoutWidth-1:0] WdLast =
        (TimeoutCycles == 32'd0) ? '0 : TimeoutWidth'(TimeoutCycles - 32'd1);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e                  state_r, state_next_s;
    logic [15:0]             status_r;
    logic                    running_r, done_r, passed_r, timeout_r, overflow_r;
    logic [TimeoutWidth-1:0] wd_cnt_r;
`ifdef SIM_STATUS_MON_DRAIN_EN
    logic                    verdict_pass_r;
`endif

    logic [7:0]          mem_r [FifoDepth];
    logic [PtrWidth-1:0] wptr_r, rptr_r, rptr_next_s;
    logic [PtrWidth:0]   cnt_r, cnt_next_s;
    logic [7:0]          head_r, head_next_s;
    logic                valid_r;

    logic st_wr_s, con_wr_s, hb_wr_s, any_wr_s;
    logic run_code_s, pass_code_s, fail_code_s, expire_s, enter_done_s;
    logic pop_s, push_s, drop_s, full_s;
    logic unused_data_s;

    assign unused_data_s = ^data_i;

    // Window decode, status code match and watchdog expiry
    always_comb begin
        st_wr_s     = wr_valid_i && (addr_i == start_addr_i);
        con_wr_s    = wr_valid_i && (addr_i == (start_addr_i + AddrWidth'(32'd4)));
        hb_wr_s     = wr_valid_i && (addr_i == (start_addr_i + AddrWidth'(32'd8)));
        any_wr_s    = st_wr_s || con_wr_s || hb_wr_s;
        run_code_s  = st_wr_s && (data_i[15:0] == 16'h4354);
        pass_code_s = st_wr_s && (data_i[15:0] == 16'h900d);
        fail_code_s = st_wr_s && (data_i[15:0] == 16'hbaad);
        // A decoded write in the expiry cycle rearms the watchdog instead of firing it
        expire_s    = WdEnable && (state_r == ST_RUNNING) && !any_wr_s && (wd_cnt_r >= WdLast);
    end

    // Test-phase next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT: begin
                if (pass_code_s || fail_code_s) begin
                    state_next_s = ST_DONE;
                end else if (run_code_s) begin
                    state_next_s = ST_RUNNING;
                end else begin
                    state_next_s = ST_BOOT;
                end
            end
            ST_RUNNING: begin
                if (pass_code_s || fail_code_s || expire_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUNNING;
                end
            end
            ST_DONE: state_next_s = ST_DONE;
            default: state_next_s = ST_BOOT;
        endcase
        enter_done_s = (state_r != ST_DONE) && (state_next_s == ST_DONE);
    end

    // Console FIFO control and next head value
    always_comb begin
        pop_s       = valid_r && char_ready_i;
        full_s      = (cnt_r == FifoFull);
        push_s      = con_wr_s && (!full_s || pop_s);
        drop_s      = con_wr_s && full_s && !pop_s;
        rptr_next_s = pop_s ? (rptr_r + PtrWidth'(1'b1)) : rptr_r;
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = cnt_r + (PtrWidth+1)'(1'b1);
            2'b01:   cnt_next_s = cnt_r - (PtrWidth+1)'(1'b1);
            default: cnt_next_s = cnt_r;
        endcase
        // The incoming character becomes the head when it lands in the slot the head moves to
        if (push_s && (wptr_r == rptr_next_s)) begin
            head_next_s = data_i[7:0];
        end else begin
            head_next_s = mem_r[rptr_next_s];
        end
    end

    // Console FIFO storage, pointers and registered head
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FifoDepth); i++) begin
                mem_r[i] <= 8'h00;
            end
            wptr_r     <= '0;
            rptr_r     <= '0;
            cnt_r      <= '0;
            head_r     <= 8'h00;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wptr_r] <= data_i[7:0];
                wptr_r        <= wptr_r + PtrWidth'(1'b1);
            end
            rptr_r  <= rptr_next_s;
            cnt_r   <= cnt_next_s;
            head_r  <= head_next_s;
            valid_r <= (cnt_next_s != '0);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Phase FSM, status register and sticky result flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r        <= ST_BOOT;
            status_r       <= 16'h0000;
            running_r      <= 1'b0;
            done_r         <= 1'b0;
            passed_r       <= 1'b0;
            timeout_r      <= 1'b0;
`ifdef SIM_STATUS_MON_DRAIN_EN
            verdict_pass_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_next_s;
            running_r <= (state_next_s == ST_RUNNING);
            if (st_wr_s) begin
                status_r <= data_i[15:0];
            end
            if (enter_done_s) begin
                timeout_r <= expire_s;
            end
`ifdef SIM_STATUS_MON_DRAIN_EN
            if (enter_done_s) begin
                verdict_pass_r <= pass_code_s;
            end
            // Report completion only once every console character has been consumed
            if ((state_r == ST_DONE) && (cnt_r == '0) && !done_r) begin
                done_r   <= 1'b1;
                passed_r <= verdict_pass_r;
            end
`else
            if (enter_done_s) begin
                done_r   <= 1'b1;
                passed_r <= pass_code_s;
            end
`endif
        end
    end

    // Heartbeat watchdog: saturating counter, rearmed by any decoded window write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_r <= '0;
        end else if (!WdEnable || (state_r != ST_RUNNING) || any_wr_s) begin
            wd_cnt_r <= '0;
        end else if (wd_cnt_r != '1) begin
            wd_cnt_r <= wd_cnt_r + TimeoutWidth'(1'b1);
        end
    end

    assign char_valid_o  = valid_r;
    assign char_data_o   = head_r;
    assign status_o      = status_r;
    assign running_o     = running_r;
    assign test_done_o   = done_r;
    assign test_passed_o = passed_r;
    assign timeout_o     = timeout_r;
    assign overflow_o    = overflow_r;
endmodule

// File: tb/tb_sim_sw_status_mon.sv
// Self-checking bench for sim_sw_status_mon: status vector table plus console scoreboard
// and hand sequences for overflow, watchdog, drain and asynchronous reset.
module tb_sim_sw_status_mon;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] base = 32'h3000_0000;
    logic        wr_valid = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] data = 32'd0;
    logic        char_valid, char_ready = 1'b0;
    logic [7:0]  char_data;
    logic [15:0] status;
    logic        running, test_done, test_passed, timeout, overflow;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  q[$];
    logic        exp_ovf = 1'b0;

    typedef struct {
        bit          rst;
        logic [15:0] code;
        logic [15:0] st;
        bit          run;
        bit          done;
        bit          pass;
    } vec_t;
    vec_t vecs[9];

    sim_sw_status_mon #(
        .AddrWidth(32), .DataWidth(32), .FifoDepth(16),
        .TimeoutCycles(100), .TimeoutWidth(32)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_addr_i(base),
        .wr_valid_i(wr_valid), .addr_i(addr), .data_i(data),
        .char_valid_o(char_valid), .char_ready_i(char_ready), .char_data_o(char_data),
        .status_o(status), .running_o(running), .test_done_o(test_done),
        .test_passed_o(test_passed), .timeout_o(timeout), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic check_flags(input string name, input logic [15:0] st, input bit run,
                               input bit done, input bit pass, input bit tmo);
        check({name, ".status"},  32'(status),      32'(st));
        check({name, ".running"}, 32'(running),     32'(run));
        check({name, ".done"},    32'(test_done),   32'(done));
        check({name, ".passed"},  32'(test_passed), 32'(pass));
        check({name, ".timeout"}, 32'(timeout),     32'(tmo));
    endtask

    // One clock step: scoreboard the console port, then drive the next inputs and update the model
    task automatic cycle(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        @(negedge clk);
        check("char_valid", 32'(char_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("char_data", 32'(char_data), 32'(q[0]));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        wr_valid = wr; addr = a; data = d; char_ready = rdy;
        if (rdy && (q.size() != 0)) void'(q.pop_front());
        if (wr && (a == base + 32'd4)) begin
            if (q.size() < 16) q.push_back(d[7:0]);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, rdy);
    endtask

    task automatic drain();
        int guard = 0;
        while ((q.size() != 0) && (guard < 64)) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b1);
            guard++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0; wr_valid = 1'b0; char_ready = 1'b0;
        #1;
        check_flags("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.char_valid", 32'(char_valid), 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'hb090, 16'hb090, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'h4354, 16'h4354, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'h900d, 16'h900d, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 16'hbaad, 16'hbaad, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 16'h4354, 16'h4354, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16'hbaad, 16'hbaad, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h4354, 16'h4354, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 16'h900d, 16'h900d, 1'b0, 1'b1, 1'b1};

        do_reset();

        // Status table: upper data bits carry junk that must not reach status_o
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) do_reset();
            cycle(1'b1, base, {16'hdead, vecs[i].code}, 1'b0);
            idle(2, 1'b0);
            check_flags($sformatf("vec%0d", i), vecs[i].st, vecs[i].run, vecs[i].done, vecs[i].pass, 1'b0);
        end

        // Pass latency: done and passed one cycle after the terminating write
        do_reset();
        cycle(1'b1, base, 32'h0000_4354, 1'b0);
        idle(1, 1'b0);
        check("seq_pass.running", 32'(running), 32'd1);
        cycle(1'b1, base, 32'h0000_900d, 1'b0);
        idle(1, 1'b0);
`ifndef SIM_STATUS_MON_DRAIN_EN
        check_flags("seq_pass", 16'h900d, 1'b0, 1'b1, 1'b1, 1'b0);
`else
        check("seq_pass.status", 32'(status), 32'h0000_900d);
`endif

        // Off-window addresses are ignored; heartbeat leaves status alone
        do_reset();
        cycle(1'b1, base + 32'd12, 32'h0000_4354, 1'b0);
        cycle(1'b1, base - 32'd4, 32'h0000_900d, 1'b0);
        cycle(1'b1, base + 32'd8, 32'h0000_4354, 1'b0);
        idle(2, 1'b0);
        check_flags("ignore", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Console "Hi\n" with ready held high
        do_reset();
        cycle(1'b1, base + 32'd4, 32'hABCD_EF48, 1'b1);
        cycle(1'b1, base + 32'd4, 32'hABCD_EF69, 1'b1);
        cycle(1'b1, base + 32'd4, 32'hABCD_EF0A, 1'b1);
        drain();
        idle(2, 1'b1);
        check("hi.valid_low", 32'(char_valid), 32'd0);

        // Head stays stable while ready is low
        cycle(1'b1, base + 32'd4, 32'h0000_0041, 1'b0);
        cycle(1'b1, base + 32'd4, 32'h0000_0042, 1'b0);
        idle(4, 1'b0);
        check("hold.head", 32'(char_data), 32'h0000_0041);
        drain();

        // Fill to full, push+pop at full, then a dropped character
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, base + 32'd4, 32'h0000_0050 + 32'(i), 1'b0);
        idle(1, 1'b0);
        check("full.no_ovf", 32'(overflow), 32'd0);
        cycle(1'b1, base + 32'd4, 32'h0000_0071, 1'b1);
        idle(1, 1'b0);
        check("full_pushpop.no_ovf", 32'(overflow), 32'd0);
        cycle(1'b1, base + 32'd4, 32'h0000_0021, 1'b0);
        idle(1, 1'b0);
        check("full_drop.ovf", 32'(overflow), 32'd1);
        drain();

        // Base-address arithmetic wraps around the top of the address space
        base = 32'hFFFF_FFFC;
        do_reset();
        cycle(1'b1, 32'hFFFF_FFFC, 32'h0000_4354, 1'b0);
        cycle(1'b1, 32'h0000_0000, 32'h0000_005A, 1'b0);
        idle(2, 1'b0);
        check("wrap.running", 32'(running), 32'd1);
        drain();
        base = 32'h3000_0000;

        // Watchdog: heartbeats every 50 cycles keep it quiet, silence lets it expire
        do_reset();
        cycle(1'b1, base, 32'h0000_4354, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(49, 1'b0);
            cycle(1'b1, base + 32'd8, 32'h0000_0000, 1'b0);
        end
        idle(99, 1'b0);
        check_flags("wd_quiet", 16'h4354, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        check_flags("wd_expired", 16'h4354, 1'b0, 1'b1, 1'b0, 1'b1);

        // Pass with console output still queued
        do_reset();
        cycle(1'b1, base, 32'h0000_4354, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, base + 32'd4, 32'h0000_0061 + 32'(i), 1'b0);
        cycle(1'b1, base, 32'h0000_900d, 1'b0);
        idle(2, 1'b0);
`ifdef SIM_STATUS_MON_DRAIN_EN
        check_flags("drain_held", 16'h900d, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        check_flags("drain_off", 16'h900d, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
        drain();
        idle(1, 1'b0);
`ifdef SIM_STATUS_MON_DRAIN_EN
        check("drain_last_pop.done", 32'(test_done), 32'd0);
`endif
        idle(1, 1'b0);
        check_flags("drain_released", 16'h900d, 1'b0, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-operation with characters queued
        cycle(1'b1, base + 32'd4, 32'h0000_0078, 1'b0);
        idle(1, 1'b0);
        do_reset();
        idle(2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
